instr_fetch_unit: RTL and testbench

- Producer end of the instruction path. Owns the PC, fetches 32-bit words from instruction memory over a req/valid handshake, and presents one instruction at a time to the control unit.
- Takes the decoder's branch decision (PCsrc) and sign-extended offset (ImmOp) back from the consumer to pick the next PC.
- Only one memory request is outstanding at any time.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Producer end of the instruction path: owns the PC, fetches one 32-bit word
// at a time from instruction memory over a req/valid handshake and presents it
// to the control unit until consumed. Only one request is ever outstanding.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   imem_req / imem_addr    one-cycle fetch pulse; address held until response
//   imem_valid / imem_rdata memory response strobe and instruction word
//   instr / instr_pc        presented instruction and its address
//   instr_valid             instr/instr_pc hold a live instruction
//   stall                   consumer not ready, hold current instruction
//   PCsrc / ImmOp           branch taken + sign-extended offset (on consume)
//   fetch_err               sticky misaligned-target flag
//
// Configuration:
//   IFU_MISALIGN_CHECK_EN   defined: a misaligned next PC sets fetch_err and
//                           parks the unit in IDLE_ERR until reset.
//                           undefined: fetch_err tied 0, targets aligned down.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned        D_WIDTH  = 32,
  parameter int unsigned        A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [D_WIDTH-1:0] imem_rdata,
  output logic [D_WIDTH-1:0] instr,
  output logic [A_WIDTH-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               PCsrc,
  input  logic [A_WIDTH-1:0] ImmOp,
  output logic               fetch_err
);

  localparam logic [D_WIDTH-1:0] NOP_INSTR  = D_WIDTH'(32'h0000_0013);
  localparam logic [A_WIDTH-1:0] PC_STEP    = A_WIDTH'(4);
  localparam logic [A_WIDTH-1:0] ALIGN_MASK = ~A_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_HOLD     = 3'd3,
    S_IDLE_ERR = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic               imem_req_q, imem_req_d;
  logic [D_WIDTH-1:0] instr_q, instr_d;
  logic [A_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_err_q, fetch_err_d;

  logic               consume_c;
  logic [A_WIDTH-1:0] next_pc_c;
  logic               misalign_c;

  // Handshake with the consumer and the candidate next PC (modulo 2^A_WIDTH).
  assign consume_c = (state_q == S_HOLD) & instr_valid_q & ~stall;
  assign next_pc_c = PCsrc ? (instr_pc_q + ImmOp) : (instr_pc_q + PC_STEP);

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_c = |next_pc_c[1:0];
`else
  assign misalign_c = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_REQ;
      S_REQ:      state_d = S_WAIT;
      S_WAIT:     if (imem_valid) state_d = S_HOLD;
      S_HOLD:     if (consume_c) state_d = misalign_c ? S_IDLE_ERR : S_REQ;
      S_IDLE_ERR: state_d = S_IDLE_ERR;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic; imem_req is high for exactly the REQ state.
  always_comb begin
    pc_d          = pc_q;
    imem_req_d    = (state_d == S_REQ);
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    case (state_q)
      S_WAIT: begin
        if (imem_valid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (consume_c) begin
          instr_valid_d = 1'b0;
          if (misalign_c) begin
            fetch_err_d = 1'b1;
          end else begin
            // Without the check, low bits are dropped so fetches stay aligned.
            pc_d = next_pc_c & ALIGN_MASK;
          end
        end
      end
      S_IDLE_ERR: instr_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, first fetch latency, stall hold,
// branch / sequential targets, address wrap, misaligned target, reset mid-WAIT.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        stall;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .D_WIDTH (32),
    .A_WIDTH (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .stall      (stall),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: waits (bounded) for imem_req at a negedge, then answers
  // after lat cycles with data. Returns in the first HOLD cycle.
  task automatic do_fetch(input int lat, input logic [31:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      for (int i = 0; i < lat; i++) @(negedge clk);
      imem_valid = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
    end
  endtask

  // Stimulus helper: releases stall for one cycle; returns one cycle later.
  task automatic do_consume(input logic src, input logic [31:0] imm);
    stall = 1'b0;
    PCsrc = src;
    ImmOp = imm;
    @(negedge clk);
    stall = 1'b1;
    PCsrc = 1'b0;
    ImmOp = 32'h0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", instr_valid); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", fetch_err); end
  endtask

  task automatic test_first_fetch();
    bit ok;
    rst_n = 1'b1;
    @(negedge clk);  // IDLE -> REQ at this edge
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL ff_req got=%0b/%h exp=1/0", imem_req, imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_valid_req got=%0b exp=0", instr_valid); end
    @(negedge clk);  // WAIT
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ff_pulse got=%0b exp=0", imem_req); end
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(negedge clk);  // HOLD (cycle 3)
    imem_valid = 1'b0;
    total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL ff_instr got=%h exp=00500093", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL ff_pc got=%h exp=0", instr_pc); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ff_valid got=%0b exp=1", instr_valid); end
    do_consume(1'b0, 32'h0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL ff_next got=%0b/%h exp=1/4", imem_req, imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_fall got=%0b exp=0", instr_valid); end
    do_fetch(1, 32'h0000_0113, ok);
    total++; if (!ok || instr_pc !== 32'h4 || instr !== 32'h0000_0113) begin bad++; $display("FAIL ff_second got=%0b/%h/%h exp=1/4/00000113", ok, instr_pc, instr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      imem_valid = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
      PCsrc      = 1'b1;
      ImmOp      = 32'h100;
      @(negedge clk);
      total++;
      if (instr !== 32'h0000_0113 || instr_pc !== 32'h4 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=%h/%h/%0b/%0b exp=00000113/4/1/0", i, instr, instr_pc, instr_valid, imem_req);
      end
    end
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    PCsrc      = 1'b0;
    ImmOp      = 32'h0;
  endtask

  task automatic test_branch();
    bit ok;
    do_consume(1'b1, 32'h0000_000C);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL br_fwd got=%0b/%h exp=1/10", imem_req, imem_addr); end
    do_fetch(1, 32'h0020_8033, ok);
    total++; if (!ok || instr_pc !== 32'h10) begin bad++; $display("FAIL br_fetch10 got=%0b/%h exp=1/10", ok, instr_pc); end
    do_consume(1'b1, 32'hFFFF_FFF8);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h08) begin bad++; $display("FAIL br_back got=%0b/%h exp=1/8", imem_req, imem_addr); end
    do_fetch(2, 32'h0000_0213, ok);
    total++; if (!ok || instr_pc !== 32'h08) begin bad++; $display("FAIL br_fetch08 got=%0b/%h exp=1/8", ok, instr_pc); end
    do_consume(1'b1, 32'h0000_0008);
    do_fetch(1, 32'h0000_0313, ok);
    total++; if (!ok || instr_pc !== 32'h10) begin bad++; $display("FAIL br_again got=%0b/%h exp=1/10", ok, instr_pc); end
    do_consume(1'b0, 32'hFFFF_FFF8);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin bad++; $display("FAIL br_seq got=%0b/%h exp=1/14", imem_req, imem_addr); end
    do_fetch(3, 32'h0000_0413, ok);
    total++; if (!ok || instr_pc !== 32'h14 || instr !== 32'h0000_0413) begin bad++; $display("FAIL br_fetch14 got=%0b/%h/%h exp=1/14/00000413", ok, instr_pc, instr); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_consume(1'b1, 32'hFFFF_FFE8);
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
    do_fetch(1, 32'h0000_0513, ok);
    total++; if (!ok || instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fetch got=%0b/%h exp=1/fffffffc", ok, instr_pc); end
    do_consume(1'b0, 32'h0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%0b/%h exp=1/0", imem_req, imem_addr); end
    do_fetch(1, 32'h0000_0613, ok);
    total++; if (!ok || instr_pc !== 32'h0) begin bad++; $display("FAIL wrap_fetch0 got=%0b/%h exp=1/0", ok, instr_pc); end
  endtask

  task automatic test_misalign();
    do_consume(1'b1, 32'h0000_0006);
`ifdef IFU_MISALIGN_CHECK_EN
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%0b exp=1", fetch_err); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%0b exp=0", instr_valid); end
    for (int i = 0; i < 8; i++) begin
      imem_valid = (i == 3);
      stall      = 1'b0;
      @(negedge clk);
      total++;
      if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL mis_park[%0d] got=%0b/%0b/%0b exp=0/1/0", i, imem_req, fetch_err, instr_valid);
      end
    end
    imem_valid = 1'b0;
    stall      = 1'b1;
`else
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL mis_align got=%0b/%h exp=1/4", imem_req, imem_addr); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL mis_noerr got=%0b exp=0", fetch_err); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    // Clean restart, then a fetch whose response would take 7 cycles.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin bad++; $display("FAIL rw_req got=%0b/%h/%0b exp=1/0/0", imem_req, imem_addr, fetch_err); end
    repeat (4) @(negedge clk);  // WAIT cycle 4
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0000_0013 || instr_pc !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL rw_async got=%0b/%h/%h/%h/%0b/%0b exp=0/0/00000013/0/0/0", imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err);
    end
    @(negedge clk);
    // Release together with the late response of the abandoned request.
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    total++;
    if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rw_late got=%0b/%h/%0b/%h exp=0/00000013/1/0", instr_valid, instr, imem_req, imem_addr);
    end
    do_fetch(1, 32'h00A0_0113, ok);
    total++;
    if (!ok || instr !== 32'h00A0_0113 || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL rw_fresh got=%0b/%h/%h/%0b exp=1/00a00113/0/1", ok, instr, instr_pc, instr_valid);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b1;
    PCsrc      = 1'b0;
    ImmOp      = 32'h0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch();
    test_wrap();
    test_misalign();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
